serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial ripple adder that adds two WIDTH-bit unsigned operands, one bit per clock, LSB first.
- The datapath is a single full-adder cell plus a registered carry.
- It is the additive counterpart of the combinational subtractor cells and is used where area matters more than latency.
- Handshake is start/busy/done. Operands are captured at start; the result is published atomically at done.

Parameters:
- WIDTH, 8, operand and sum width in bits. Must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request a new addition; sampled only when not busy
- a  input  WIDTH  operand A; captured on the accepted start edge only
- b  input  WIDTH  operand B; captured on the accepted start edge only
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle on
- sum  output  WIDTH  (a+b) mod 2^WIDTH; held until the next completion
- cout  output  1  carry out of bit WIDTH-1; held with sum

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry and bit counter are cleared.
  - Reset has priority over every other input.
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 at an edge: load sh_a<=a, sh_b<=b, carry<=0, cnt<=0; go to ADD; busy<=1.
  - start=0: remain in IDLE.
- ADD: at each edge:
  - s = sh_a[0] ^ sh_b[0] ^ carry.
  - carry <= majority(sh_a[0], sh_b[0], carry).
  - Working result shifts right with s entering at the MSB.
  - sh_a and sh_b shift right with 0 filled in.
  - cnt increments.
  - On the edge that processes bit WIDTH-1 (cnt==WIDTH-1):
    - sum <= final working result, including that edge's s.
    - cout <= that edge's carry-out.
    - busy<=0, done<=1; go to DONE.
- DONE:
  - Lasts exactly one cycle; done=1.
  - start=1 at this edge is accepted exactly as in IDLE (back-to-back operation; done falls, busy rises).
  - Otherwise go to IDLE; done<=0.
- Latency: start sampled at edge E0 → busy high after E0 → done high after edge E(WIDTH), sum/cout valid at that time. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored. It is not queued, and operand changes have no effect.
- sum and cout outputs do not change during ADD. They keep the previous result (0 after reset) until the completion edge.
- Reset during ADD or DONE aborts the operation: no done pulse, sum/cout forced to 0.
- WIDTH=1: ADD lasts a single edge; done follows start by 2 edges (E0 accept, E1 complete).
- Internal counter width is clog2(WIDTH) (min 1). It never wraps during an operation.
- Arithmetic is unsigned. {cout,sum} equals a+b exactly as a WIDTH+1-bit value.

Test Plan:
- WIDTH=8, a=0x3C, b=0x0F, pulse start → busy high for 8 cycles, then done one cycle; sum=0x4B, cout=0. sum reads 0x00 throughout busy.
- WIDTH=8, a=0xFF, b=0x01 → sum=0x00, cout=1. Then a=0xFF, b=0xFF → sum=0xFE, cout=1. Verify the previous result is held until the new done.
- Start ignored while busy: start with a=0x10, b=0x20, re-pulse start with a=0xAA, b=0x55 at cycle 3 → exactly one done, sum=0x30, cout=0, no extra busy period.
- Back-to-back: hold start=1 continuously with fixed a=0x81, b=0x81 → done pulses every 9 cycles, each with sum=0x02, cout=1. busy low only in done cycles.
- Reset mid-op: start a=0xF0, b=0x0F, assert rst at cycle 4 for one cycle → no done ever, busy=0, sum=0, cout=0. A fresh start then gives sum=0xFF, cout=0.
- WIDTH=1 instance: all four (a,b) pairs → {cout,sum} = 00, 01, 01, 10; done occurs 2 edges after start.

Source files
------------

// File: rtl/serial_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_adder_if                                           |
// | Brief    : start/busy/done handshake and operand/result bus for the  |
// |            bit-serial adder.                                         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_adder                                              |
// | Brief    : Bit-serial unsigned adder, one full-adder cell plus a     |
// |            registered carry, LSB first, start/busy/done handshake.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_a_q;
  logic [WIDTH-1:0] sh_b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             w_sum_bit;
  logic             carry_d;
  logic [WIDTH-1:0] acc_d;

  assign w_sum_bit = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
  assign carry_d   = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & carry_q) | (sh_b_q[0] & carry_q);

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign acc_d = w_sum_bit;
    end else begin : g_acc_wn
      assign acc_d = {w_sum_bit, acc_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sh_a_q  <= bus.a;
            sh_b_q  <= bus.b;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ADD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ADD: begin
          sh_a_q  <= sh_a_q >> 1;
          sh_b_q  <= sh_b_q >> 1;
          acc_q   <= acc_d;
          carry_q <= carry_d;
          if (cnt_q == LAST_CNT) begin
            sum_q   <= acc_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
`default_nettype wire
